// File: rtl/xnor_rr_sched.sv
// Round-robin scheduler sharing one 3-input XNOR unit among N_REQ requesters.
// Each accepted operand is evaluated once and returned tagged with its owner's ID.
module xnor_rr_sched #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [3*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_data,
   output logic [ID_W-1:0]    res_id,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [ID_W-1:0] last_ptr;
   logic [ID_W-1:0] cur_id;
   logic [2:0]      operand;

   logic            hi_found;
   logic            lo_found;
   logic [ID_W-1:0] hi_id;
   logic [ID_W-1:0] lo_id;
   logic [2:0]      hi_opnd;
   logic [2:0]      lo_opnd;

   logic            grant_found;
   logic [ID_W-1:0] grant_id;
   logic [2:0]      grant_opnd;
   logic [N_REQ-1:0] grant_onehot;
   logic            accept;

   // Rotating priority without a barrel shifter: requesters above the pointer
   // win first, otherwise the lowest-indexed requester at or below it wraps in.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      hi_opnd  = '0;
      lo_opnd  = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (!hi_found && req_valid[j] && (j > int'(last_ptr))) begin
            hi_found = 1'b1;
            hi_id    = ID_W'(j);
            hi_opnd  = req_data[3*j +: 3];
         end
         if (!lo_found && req_valid[j]) begin
            lo_found = 1'b1;
            lo_id    = ID_W'(j);
            lo_opnd  = req_data[3*j +: 3];
         end
      end
   end

   always_comb begin
      grant_found  = hi_found | lo_found;
      grant_id     = hi_found ? hi_id   : lo_id;
      grant_opnd   = hi_found ? hi_opnd : lo_opnd;
      grant_onehot = '0;
      for (int j = 0; j < N_REQ; j++) begin
         grant_onehot[j] = grant_found && (grant_id == ID_W'(j));
      end
   end

   assign accept = (state == IDLE) && grant_found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_found) state_next = EVAL;
         EVAL:    state_next = OUT;
         OUT:     if (res_valid && res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The accept strobe is gated by rst_n so it drops the moment reset asserts,
   // even though requesters may still be presenting valid operands.
   always_comb begin
      req_ready = '0;
      busy      = (state != IDLE);
      if (rst_n && accept) begin
         req_ready = grant_onehot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operand   <= '0;
         cur_id    <= '0;
         last_ptr  <= ID_W'(N_REQ - 1);
         res_valid <= 1'b0;
         res_data  <= 1'b0;
         res_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  operand  <= grant_opnd;
                  cur_id   <= grant_id;
                  last_ptr <= grant_id;
               end
            end
            EVAL: begin
               res_data  <= ~^operand;
               res_id    <= cur_id;
               res_valid <= 1'b1;
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
